constraint_sample_harvester: RTL

- Stimulus/collection stage wrapped around a generated constraint checker.
- Drives pseudo-random candidate vectors onto the checker's concatenated input bus each cycle and reads back the checker's combinational `x` in the same cycle.
- Buffers satisfying candidates in a FIFO and streams them out over a valid/ready interface.
- Terminates after a requested sample count or an attempt budget.

---
 rtl/harvester_pkg.sv | 46 ++++
 rtl/harvester_fifo.sv | 78 +++++++
 rtl/constraint_sample_harvester.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/harvester_pkg.sv
`default_nettype none
// ============================================================================
// Module      : harvester_pkg
// Description : Shared types and helpers for the constraint sample harvester:
//               FSM state encoding, xorshift32 lane width, golden-ratio lane
//               seed spreading constant, lane-count and PRNG step functions.
// Revision    : 1.0 - initial release
// ============================================================================
package harvester_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int          XS_LANE_W     = 32;
    localparam logic [31:0] c_GOLDEN_SEED = 32'h9E3779B9;

    // Number of 32-bit xorshift lanes needed to cover a candidate of width w.
    function automatic int lane_count(input int w);
        return (w + XS_LANE_W - 1) / XS_LANE_W;
    endfunction

    // One xorshift32 step (13/17/5 triple).
    function automatic logic [31:0] xs_step(input logic [31:0] v);
        logic [31:0] x;
        x = v;
        x = x ^ (x << 13);
        x = x ^ (x >> 17);
        x = x ^ (x << 5);
        return x;
    endfunction

    // Per-lane seed: spread the user seed across lanes with the golden-ratio
    // constant; a zero state would lock xorshift at zero, so it becomes 1.
    function automatic logic [31:0] seed_lane(input logic [31:0] seed, input int k);
        logic [31:0] kk;
        logic [31:0] v;
        kk = 32'(k);
        v  = seed ^ (kk * c_GOLDEN_SEED);
        return (v == 32'h0) ? 32'h1 : v;
    endfunction

endpackage : harvester_pkg
`default_nettype wire

// File: rtl/harvester_fifo.sv
`default_nettype none
// ============================================================================
// Module      : harvester_fifo
// Description : Synchronous FIFO holding accepted samples. Valid/ready read
//               side with the head presented combinationally; the full flag
//               is registered state so a same-cycle pop never feeds back into
//               the producer's push decision.
// Ports       : clk, rst_n   - clock, asynchronous active-low reset
//               i_push       - write request (ignored when full unless popping)
//               i_data       - write data
//               o_full       - FIFO holds DEPTH entries
//               o_valid      - FIFO non-empty
//               o_data       - head entry (zero when empty)
//               i_ready      - consumer ready; pop when o_valid && i_ready
// Revision    : 1.0 - initial release
// ============================================================================
module harvester_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ready
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;

    logic w_empty;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_count == '0);
    assign o_full  = (r_count == (c_AW+1)'(DEPTH));
    assign o_valid = !w_empty;
    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];

    assign w_pop  = i_ready && !w_empty;
    // A pop in the same cycle frees the slot the push is about to use.
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_AW+1)'(1);
                2'b01:   r_count <= r_count - (c_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : harvester_fifo
`default_nettype wire

// File: rtl/constraint_sample_harvester.sv
`default_nettype none
// ============================================================================
// Module      : constraint_sample_harvester
// Description : Stimulus/collection stage around a combinational constraint
//               checker. Drives xorshift32 candidates on cand_o, samples the
//               checker verdict x_i in the same cycle, buffers satisfying
//               candidates in a FIFO and streams them out via valid/ready.
//               A run ends on reaching the sample target or the attempt
//               budget.
// Ports       : clk, rst_n        - clock, asynchronous active-low reset
//               start_i           - start pulse (honoured only in IDLE)
//               seed_i            - PRNG seed
//               num_samples_i     - hit target (0 = finish immediately)
//               max_attempts_i    - attempt budget (0 = unlimited)
//               cand_o / x_i      - candidate to checker / checker verdict
//               busy_o, done_o    - running / one-cycle completion pulse
//               timeout_o         - sticky budget-exhausted flag
//               hit_cnt_o         - samples accepted this run
//               smp_valid_o, smp_data_o, smp_ready_i - sample stream
// Options     : HARVEST_DEDUP_EN  - reject a hit equal to the last pushed
//                                   candidate of the run
// Revision    : 1.0 - initial release
// ============================================================================
module constraint_sample_harvester
    import harvester_pkg::*;
#(
    parameter int CAND_W     = 185,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16,
    parameter int ATT_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [31:0]       seed_i,
    input  logic [CNT_W-1:0]  num_samples_i,
    input  logic [ATT_W-1:0]  max_attempts_i,
    output logic [CAND_W-1:0] cand_o,
    input  logic              x_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              timeout_o,
    output logic [CNT_W-1:0]  hit_cnt_o,
    output logic              smp_valid_o,
    output logic [CAND_W-1:0] smp_data_o,
    input  logic              smp_ready_i
);

    localparam int c_NL = lane_count(CAND_W);
    localparam int c_LW = c_NL * XS_LANE_W;

    state_t            r_state;
    logic [c_LW-1:0]   r_lanes;
    logic [CAND_W-1:0] r_cand;
    logic [CNT_W-1:0]  r_target;
    logic [ATT_W-1:0]  r_budget;
    logic [ATT_W-1:0]  r_att;
    logic [CNT_W-1:0]  r_hit;
    logic              r_busy;
    logic              r_done;
    logic              r_timeout;

    logic [c_LW-1:0]   w_lanes_seed;
    logic [c_LW-1:0]   w_lanes_next;
    logic              w_start_acc;
    logic              w_run;
    logic              w_dup;
    logic              w_accept;
    logic              w_fifo_full;
    logic              w_stall;
    logic              w_step;
    logic              w_push;
    logic [CNT_W-1:0]  w_hit_nxt;
    logic [ATT_W-1:0]  w_att_nxt;
    logic              w_tgt_met;
    logic              w_bud_met;

    // ------------------------------------------------------------------
    // PRNG lanes
    // ------------------------------------------------------------------
    for (genvar k = 0; k < c_NL; k++) begin : g_lane
        assign w_lanes_seed[k*XS_LANE_W +: XS_LANE_W] = seed_lane(seed_i, k);
        assign w_lanes_next[k*XS_LANE_W +: XS_LANE_W] =
            xs_step(r_lanes[k*XS_LANE_W +: XS_LANE_W]);
    end

    // ------------------------------------------------------------------
    // Attempt decode
    // ------------------------------------------------------------------
    assign w_start_acc = (r_state == IDLE) && start_i;
    assign w_run       = (r_state == RUN);
    assign w_accept    = x_i && !w_dup;
    // Full is the registered flag, so a concurrent pop only helps next cycle.
    assign w_stall     = w_run && w_accept && w_fifo_full;
    assign w_step      = w_run && !w_stall;
    assign w_push      = w_step && w_accept;

    assign w_hit_nxt = (w_push && (r_hit != '1)) ? r_hit + CNT_W'(1) : r_hit;
    assign w_att_nxt = (r_att != '1) ? r_att + ATT_W'(1) : r_att;
    assign w_tgt_met = (w_hit_nxt == r_target);
    assign w_bud_met = (r_budget != '0) && (w_att_nxt == r_budget);

`ifdef HARVEST_DEDUP_EN
    logic [CAND_W-1:0] r_last;
    logic              r_last_vld;

    assign w_dup = r_last_vld && (r_cand == r_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last     <= '0;
            r_last_vld <= 1'b0;
        end else if (w_start_acc) begin
            r_last     <= '0;
            r_last_vld <= 1'b0;
        end else if (w_push) begin
            r_last     <= r_cand;
            r_last_vld <= 1'b1;
        end
    end
`else
    assign w_dup = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_lanes   <= {c_NL{32'h1}};
            r_cand    <= '0;
            r_target  <= '0;
            r_budget  <= '0;
            r_att     <= '0;
            r_hit     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_target  <= num_samples_i;
                        r_budget  <= max_attempts_i;
                        r_att     <= '0;
                        r_hit     <= '0;
                        r_timeout <= 1'b0;
                        if (num_samples_i == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            // Seeded lanes are the first candidate of the run.
                            r_lanes <= w_lanes_seed;
                            r_cand  <= w_lanes_seed[CAND_W-1:0];
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (w_step) begin
                        r_att   <= w_att_nxt;
                        r_hit   <= w_hit_nxt;
                        r_lanes <= w_lanes_next;
                        r_cand  <= w_lanes_next[CAND_W-1:0];
                        if (w_tgt_met || w_bud_met) begin
                            r_state   <= DONE;
                            r_done    <= 1'b1;
                            r_busy    <= 1'b0;
                            // Reaching the target takes precedence over budget.
                            r_timeout <= !w_tgt_met;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sample buffer
    // ------------------------------------------------------------------
    harvester_fifo #(
        .WIDTH (CAND_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (r_cand),
        .o_full  (w_fifo_full),
        .o_valid (smp_valid_o),
        .o_data  (smp_data_o),
        .i_ready (smp_ready_i)
    );

    assign cand_o    = r_cand;
    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign timeout_o = r_timeout;
    assign hit_cnt_o = r_hit;

endmodule : constraint_sample_harvester
`default_nettype wire
